// File: rtl/out_uart_tx_pkg.sv
// rtl/out_uart_tx_pkg.sv - shared state encoding and framing constants for out_uart_tx
package out_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int UART_BYTES_PER_WORD = 4;
    localparam int UART_DATA_BITS      = 8;

    // Bit position inside the 32-bit word for a given byte and bit index.
    function automatic logic [4:0] bit_pos(input logic [1:0] byte_idx, input logic [2:0] bit_idx);
        return {byte_idx, bit_idx};
    endfunction

endpackage

// File: rtl/out_uart_tx_sync_fifo.sv
// rtl/out_uart_tx_sync_fifo.sv - synchronous first-word-fall-through FIFO
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - captures changes of the result bus and streams each word over UART 8N1
module out_uart_tx
    import out_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        en,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] words_sent
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);
    localparam logic [1:0]    BYTE_LAST = 2'(UART_BYTES_PER_WORD - 1);

    tx_state_e   state_q;
    logic        txd_q;
    logic [CW-1:0] bit_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] shift_q;
    logic [15:0] words_sent_q;
    logic [31:0] prev_q;
    logic        overflow_q;
    logic        overflow_d;

    logic        change;
    logic        pop;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        bit_last;

    assign change     = en && (data_in != prev_q);
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign bit_last   = (bit_cnt_q == BIT_LAST);
    assign overflow_d = overflow_q || (change && fifo_full);

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // prev_q follows every enabled change, including ones the FIFO drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (change) prev_q <= data_in;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            txd_q        <= 1'b1;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            words_sent_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_dout;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[bit_pos(byte_idx_q, 3'd0)];
                        state_q   <= ST_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == IDX_LAST) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[bit_pos(byte_idx_q, bit_idx_q + 3'd1)];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_last) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q != BYTE_LAST) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            txd_q      <= 1'b0;
                            state_q    <= ST_START;
                        end else begin
                            words_sent_q <= words_sent_q + 16'd1;
                            state_q      <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow   = overflow_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - scoreboard bench decoding the UART line of out_uart_tx
module tb_out_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        en;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [15:0] words_sent;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    bit          rx_active = 1'b0;
    int          rx_cnt = 0;
    logic [7:0]  rx_byte;

    out_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .en         (en),
        .txd        (txd),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_idle_timeout"}, {31'd0, done}, 32'd1);
    endtask

    // Line monitor: start bit detected at the first low sample, bit i sampled at 4*i+5.
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
                rx_byte[(rx_cnt - 5) / 4] = txd;
            if (rx_cnt == 37) begin
                check("rx_stop_bit", {31'd0, txd}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got byte %h expected none at %0t", rx_byte, $time);
                end else begin
                    check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] v;

        // Reset and quiet line
        rst = 1'b1; data_in = '0; en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_words", {16'd0, words_sent}, 32'd0);
        repeat (200) tick();
        check("quiet_busy", {31'd0, busy}, 32'd0);

        // Single word with edge-exact timing
        data_in = 32'h12345678;
        expect_word(32'h12345678);
        tick();
        check("single_pre_start", {31'd0, txd}, 32'd1);
        tick();
        check("single_start_bit", {31'd0, txd}, 32'd0);
        repeat (159) tick();
        check("single_words_before", {16'd0, words_sent}, 32'd0);
        tick();
        check("single_words_done", {16'd0, words_sent}, 32'd1);
        check("single_busy_fall", {31'd0, busy}, 32'd0);
        repeat (5) tick();

        // en gating
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 32'h0F00_0000 + 32'(i);
            tick();
        end
        repeat (20) tick();
        check("gated_busy", {31'd0, busy}, 32'd0);
        check("gated_words", {16'd0, words_sent}, 32'd1);
        en = 1'b1;
        data_in = 32'hA5A5A5A5;
        expect_word(32'hA5A5A5A5);
        tick();
        tick();
        wait_idle(200, "gated");
        check("gated_one_word", {16'd0, words_sent}, 32'd2);

        // Overflow: six back-to-back values, the sixth is dropped
        for (int i = 0; i < 6; i++) begin
            v = 32'h1111_1111 * 32'(i + 1);
            data_in = v;
            if (i < 5) expect_word(v);
            tick();
            if (i == 4) check("ovf_full", {31'd0, fifo_full}, 32'd1);
            if (i == 4) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        wait_idle(5 * 170 + 50, "ovf");
        check("ovf_words", {16'd0, words_sent}, 32'd7);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset during DATA of byte 2
        data_in = 32'h0BADF00D;
        expect_word(32'h0BADF00D);
        tick();
        data_in = 32'hCAFEF00D;
        tick();
        repeat (90) tick();
        check("midrst_bytes_left", exp_q.size(), 32'd2);
        rst = 1'b1;
        data_in = '0;
        exp_q.delete();
        tick();
        check("midrst_txd", {31'd0, txd}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_full", {31'd0, fifo_full}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        check("midrst_words", {16'd0, words_sent}, 32'd0);
        rst = 1'b0;
        tick();
        data_in = 32'hDEADBEEF;
        expect_word(32'hDEADBEEF);
        tick();
        tick();
        wait_idle(200, "post_rst");
        check("post_rst_words", {16'd0, words_sent}, 32'd1);

        // words_sent rollover
        force dut.words_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.words_sent_q;
        tick();
        data_in = 32'h5A5A0001;
        expect_word(32'h5A5A0001);
        tick();
        tick();
        wait_idle(200, "wrap");
        check("wrap_words", {16'd0, words_sent}, 32'd0);

        // FIFO pointer wrap over repeated fill/drain rounds
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                v = 32'h7000_0000 | (32'(r) << 8) | 32'(k + 1);
                data_in = v;
                expect_word(v);
                tick();
            end
            wait_idle(4 * 170 + 50, "fill_drain");
            check("fill_drain_words", {16'd0, words_sent}, 32'(4 * (r + 1)));
        end
        check("fill_drain_overflow", {31'd0, overflow}, 32'd0);

        repeat (10) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
